// File: rtl/jtcommando_dwnld.sv
// ROM download adapter: splits the ioctl byte stream into SDRAM write requests
// (with a one-entry skid buffer) and one-hot strobes for the on-chip PROMs.
module jtcommando_dwnld #(
  parameter logic [21:0] PROM_START = 22'h04_4000,
  parameter int unsigned PROM_COUNT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [21:0]           ioctl_addr,
  input  logic [7:0]            ioctl_data,
  input  logic                  ioctl_wr,
  output logic [21:0]           prog_addr,
  output logic [7:0]            prog_data,
  output logic [1:0]            prog_mask,
  output logic                  prog_we,
  input  logic                  prog_ack,
  output logic [PROM_COUNT-1:0] prom_we,
  output logic [7:0]            prom_addr,
  output logic [7:0]            prom_din,
  output logic                  dwnld_done,
  output logic                  overrun
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } word_t;

  localparam word_t WORD_RST = '{addr: '0, data: '0, mask: 2'b11};

  state_e                state_q, state_d;
  word_t                 out_q, out_d, buf_q, buf_d, new_w;
  logic                  buf_full_q, buf_full_d;
  logic                  overrun_q, overrun_d;
  logic                  dl_q;
  logic                  pend_q, pend_d;
  logic                  done_q, done_d;
  logic [PROM_COUNT-1:0] prom_we_q, prom_we_d;
  logic [7:0]            prom_addr_q, prom_addr_d;
  logic [7:0]            prom_din_q, prom_din_d;

  logic        wr_ok, in_prom, sdram_wr, prom_hit, dl_rise, dl_fall;
  logic [21:0] prom_idx;

  assign wr_ok    = ioctl_wr & downloading;
  assign in_prom  = ioctl_addr >= PROM_START;
  assign sdram_wr = wr_ok & ~in_prom;
  assign prom_idx = (ioctl_addr - PROM_START) >> 8;
  assign prom_hit = wr_ok & in_prom & (32'(prom_idx) < PROM_COUNT);
  assign dl_rise  = downloading & ~dl_q;
  assign dl_fall  = ~downloading & dl_q;

  assign new_w = '{addr: {1'b0, ioctl_addr[21:1]},
                   data: ioctl_data,
                   mask: ioctl_addr[0] ? 2'b01 : 2'b10};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable gets a default at the top of the block; a missing
  // branch then means "hold", never an inferred latch.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    overrun_d  = dl_rise ? 1'b0 : overrun_q;

    unique case (state_q)
      IDLE: begin
        if (sdram_wr) begin
          out_d   = new_w;
          state_d = REQ;
        end
      end
      REQ: begin
        if (prog_ack) begin
          if (buf_full_q) begin
            // Drain the buffer; a same-cycle byte refills the freed slot.
            out_d = buf_q;
            if (sdram_wr) buf_d = new_w;
            else          buf_full_d = 1'b0;
          end else if (sdram_wr) begin
            out_d = new_w;
          end else begin
            state_d = IDLE;
          end
        end else if (sdram_wr) begin
          if (!buf_full_q) begin
            buf_d      = new_w;
            buf_full_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Done waits for the SDRAM side to be fully drained after the falling edge.
    pend_d = (pend_q | dl_fall) & ~dl_rise;
    done_d = pend_d & (state_d == IDLE) & ~buf_full_d;
    if (done_d) pend_d = 1'b0;
  end

  always_comb begin
    prom_we_d   = prom_hit ? (PROM_COUNT'(1) << prom_idx) : '0;
    prom_addr_d = prom_hit ? ioctl_addr[7:0] : prom_addr_q;
    prom_din_d  = prom_hit ? ioctl_data      : prom_din_q;
  end

  // NOTE: the skid buffer is reset along with everything else; it is a single
  // entry, and a clean value keeps post-reset behaviour fully deterministic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= WORD_RST;
      buf_q       <= WORD_RST;
      buf_full_q  <= 1'b0;
      overrun_q   <= 1'b0;
      dl_q        <= 1'b0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      prom_we_q   <= '0;
      prom_addr_q <= '0;
      prom_din_q  <= '0;
    end else begin
      out_q       <= out_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      overrun_q   <= overrun_d;
      dl_q        <= downloading;
      pend_q      <= pend_d;
      done_q      <= done_d;
      prom_we_q   <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_din_q  <= prom_din_d;
    end
  end

  always_comb begin
    prog_we    = (state_q == REQ);
    prog_addr  = out_q.addr;
    prog_data  = out_q.data;
    prog_mask  = out_q.mask;
    prom_we    = prom_we_q;
    prom_addr  = prom_addr_q;
    prom_din   = prom_din_q;
    dwnld_done = done_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_jtcommando_dwnld.sv
// Scoreboard bench for jtcommando_dwnld: a queue-level model of the download
// adapter predicts SDRAM writes, PROM strobes, overrun and completion pulses.
module tb_jtcommando_dwnld;

  localparam logic [21:0] PS = 22'h04_4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_ack = 1'b0;
  logic [7:0]  prom_we;
  logic [7:0]  prom_addr;
  logic [7:0]  prom_din;
  logic        dwnld_done;
  logic        overrun;

  jtcommando_dwnld #(.PROM_START(PS), .PROM_COUNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_ack(prog_ack),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_din(prom_din),
    .dwnld_done(dwnld_done), .overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [21:0] a; logic [7:0] d; logic [1:0] m; } sdw_t;
  typedef struct { logic [7:0] we; logic [7:0] a; logic [7:0] d; } prw_t;

  sdw_t wq[$];
  prw_t pq[$];

  int checks = 0;
  int errors = 0;

  // Model: number of SDRAM writes accepted but not yet acknowledged (<= 2).
  int occ = 0;
  bit ovr_m = 0, pend_m = 0, prev_dl = 0, exp_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transfer.
  initial forever begin
    @(negedge clk);
    #1;
    if (prog_we && prog_ack) begin
      if (wq.size() == 0) check("prog_unexpected", 64'(prog_addr), 64'h3f_ffff);
      else begin
        sdw_t e;
        e = wq.pop_front();
        check("prog_addr", 64'(prog_addr), 64'(e.a));
        check("prog_data", 64'(prog_data), 64'(e.d));
        check("prog_mask", 64'(prog_mask), 64'(e.m));
      end
    end
    if (prom_we != 8'h00) begin
      if (pq.size() == 0) check("prom_unexpected", 64'(prom_we), 64'h0);
      else begin
        prw_t p;
        p = pq.pop_front();
        check("prom_we", 64'(prom_we), 64'(p.we));
        check("prom_addr", 64'(prom_addr), 64'(p.a));
        check("prom_din", 64'(prom_din), 64'(p.d));
      end
    end
  end

  // One clock cycle of stimulus; the model advances to the state after the edge.
  task automatic step(input bit wr, input logic [21:0] a, input logic [7:0] d,
                      input bit ack, input bit dl, input bit rst, input bit raw_ack);
    bit ack_eff, rise, fall;
    logic [21:0] off;
    int idx;
    sdw_t w;
    prw_t p;
    @(negedge clk);
    check("prog_we", 64'(prog_we), 64'(occ > 0));
    check("overrun", 64'(overrun), 64'(ovr_m));
    check("dwnld_done", 64'(dwnld_done), 64'(exp_done));
    ack_eff     = ack && (occ > 0);
    rst_n       = !rst;
    ioctl_wr    = wr;
    ioctl_addr  = a;
    ioctl_data  = d;
    downloading = dl;
    prog_ack    = ack_eff | raw_ack;
    if (rst) begin
      occ = 0; wq.delete(); ovr_m = 0; pend_m = 0; exp_done = 0; prev_dl = 0;
      return;
    end
    rise = dl && !prev_dl;
    fall = !dl && prev_dl;
    if (rise) ovr_m = 0;
    if (ack_eff) occ--;
    if (wr && dl) begin
      if (a < PS) begin
        if (occ < 2) begin
          w.a = a >> 1; w.d = d; w.m = a[0] ? 2'b01 : 2'b10;
          wq.push_back(w);
          occ++;
        end else ovr_m = 1;
      end else begin
        off = a - PS;
        idx = int'(off >> 8);
        if (idx < 8) begin
          p.we = 8'(1 << idx); p.a = a[7:0]; p.d = d;
          pq.push_back(p);
        end
      end
    end
    if (fall) pend_m = 1;
    if (rise) pend_m = 0;
    exp_done = pend_m && (occ == 0);
    if (exp_done) pend_m = 0;
    prev_dl = dl;
  endtask

  task automatic idle(input int n, input bit ack, input bit dl);
    for (int i = 0; i < n; i++) step(0, '0, '0, ack, dl, 0, 0);
  endtask

  task automatic check_reset_outputs();
    @(posedge clk);
    #1;
    check("rst_prog_we", 64'(prog_we), 64'h0);
    check("rst_prog_addr", 64'(prog_addr), 64'h0);
    check("rst_prog_data", 64'(prog_data), 64'h0);
    check("rst_prog_mask", 64'(prog_mask), 64'h3);
    check("rst_prom_we", 64'(prom_we), 64'h0);
    check("rst_prom_addr", 64'(prom_addr), 64'h0);
    check("rst_prom_din", 64'(prom_din), 64'h0);
    check("rst_done", 64'(dwnld_done), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
  endtask

  initial begin
    bit dl_r;
    bit wr_r;
    logic [21:0] a_r;

    check_reset_outputs();
    idle(2, 0, 1);

    // Two single writes, each acknowledged three cycles after prog_we rises.
    step(1, 22'h000000, 8'hA5, 0, 1, 0, 0);
    idle(3, 0, 1);
    step(0, '0, '0, 1, 1, 0, 0);
    idle(3, 0, 1);
    step(1, 22'h000001, 8'h5A, 0, 1, 0, 0);
    idle(3, 0, 1);
    step(0, '0, '0, 1, 1, 0, 0);
    idle(3, 0, 1);

    // Burst of three with a stalled controller: third byte overruns.
    step(1, 22'h000010, 8'h11, 0, 1, 0, 0);
    step(1, 22'h000011, 8'h22, 0, 1, 0, 0);
    step(1, 22'h000012, 8'h33, 0, 1, 0, 0);
    idle(10, 0, 1);
    idle(6, 1, 1);

    // PROM hit and PROM index past the last PROM.
    step(1, PS + 22'h203, 8'h3C, 0, 1, 0, 0);
    idle(3, 0, 1);
    step(1, PS + 22'h800, 8'h77, 0, 1, 0, 0);
    idle(3, 0, 1);

    // downloading falls with one write in flight and one buffered.
    step(1, 22'h000020, 8'h44, 0, 1, 0, 0);
    step(1, 22'h000021, 8'h55, 0, 1, 0, 0);
    idle(3, 0, 0);
    idle(2, 1, 0);
    idle(4, 0, 0);
    idle(3, 0, 1);

    // Reset during an outstanding request, then a stray acknowledge.
    step(1, 22'h000030, 8'h66, 0, 1, 0, 0);
    idle(2, 0, 1);
    step(0, '0, '0, 0, 1, 1, 0);
    check_reset_outputs();
    step(0, '0, '0, 0, 1, 0, 1);
    idle(4, 0, 1);

    // Randomized traffic against the model.
    dl_r = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) dl_r = !dl_r;
      if ($urandom_range(0, 799) == 0) begin
        step(0, '0, '0, 0, dl_r, 1, 0);
      end else begin
        wr_r = ($urandom_range(0, 99) < 40);
        if ($urandom_range(0, 3) == 0) a_r = PS + 22'($urandom_range(0, 32'hA00));
        else                           a_r = 22'($urandom_range(0, 32'h4_3FFF));
        step(wr_r, a_r, 8'($urandom), ($urandom_range(0, 99) < 30), dl_r, 0, 0);
      end
    end

    idle(20, 1, 1);
    check("sdram_queue_empty", 64'(wq.size()), 64'h0);
    check("prom_queue_empty", 64'(pq.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
